cdb_bcast: RTL and testbench

CDB_BCAST -- requirements
Module: cdb_bcast

---
 rtl/cdb_bcast.sv | 118 +++++++++++
 tb/tb_cdb_bcast.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_bcast.sv
// cdb_bcast: two-source (ALU, LSB) result FIFOs with round-robin broadcast onto the common data bus.
// Define CDB_BCAST_BYPASS_EN to let a winning push into an empty FIFO go straight to the bus.
module cdb_bcast_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 41
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clr,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk_in)
    if (wr) mem[wp] <= din;
  assign dout = mem[rp];
endmodule

module cdb_bcast #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_value,
  input  logic             lsb_valid,
  output logic             lsb_ready,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [4:0]       lsb_rd,
  input  logic [31:0]      lsb_value,
  output logic             have_modify,
  output logic [TAG_W-1:0] entry_modify,
  output logic [4:0]       destination_modify,
  output logic [31:0]      value_modify
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W = TAG_W + 37;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [AW:0] a_cnt, l_cnt;
  logic [W-1:0] a_din, l_din, a_dout, l_dout, bus;
  logic en, a_push, l_push, a_ne, l_ne, a_req, l_req, any, sel_l;
  logic a_pop, l_pop, a_wr, l_wr, rr;
  assign en = rdy_in & ~flush_in;
  assign alu_ready = rdy_in & (a_cnt != FULL);
  assign lsb_ready = rdy_in & (l_cnt != FULL);
  assign a_push = en & alu_valid & alu_ready;
  assign l_push = en & lsb_valid & lsb_ready;
  assign a_din = {alu_tag, alu_rd, alu_value};
  assign l_din = {lsb_tag, lsb_rd, lsb_value};
  assign a_ne = a_cnt != '0;
  assign l_ne = l_cnt != '0;
`ifdef CDB_BCAST_BYPASS_EN
  // an accepted push competes for the bus as if it were already queued
  assign a_req = a_ne | a_push;
  assign l_req = l_ne | l_push;
  assign a_wr = a_push & ~(en & ~sel_l & ~a_ne);
  assign l_wr = l_push & ~(en & sel_l & ~l_ne);
  assign bus = sel_l ? (l_ne ? l_dout : l_din) : (a_ne ? a_dout : a_din);
`else
  assign a_req = a_ne;
  assign l_req = l_ne;
  assign a_wr = a_push;
  assign l_wr = l_push;
  assign bus = sel_l ? l_dout : a_dout;
`endif
  assign any = a_req | l_req;
  assign sel_l = (a_req & l_req) ? rr : l_req;
  assign a_pop = en & any & ~sel_l & a_ne;
  assign l_pop = en & any & sel_l & l_ne;
  cdb_bcast_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_alu (
    .clk_in(clk_in), .rst_in(rst_in), .clr(rdy_in & flush_in),
    .wr(a_wr), .rd(a_pop), .din(a_din), .dout(a_dout), .cnt(a_cnt)
  );
  cdb_bcast_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_lsb (
    .clk_in(clk_in), .rst_in(rst_in), .clr(rdy_in & flush_in),
    .wr(l_wr), .rd(l_pop), .din(l_din), .dout(l_dout), .cnt(l_cnt)
  );
  // stall and flush both drop the pulse so a held payload is never rebroadcast
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      have_modify <= 1'b0;
      entry_modify <= '0;
      destination_modify <= '0;
      value_modify <= '0;
      rr <= 1'b0;
    end else if (!en) begin
      have_modify <= 1'b0;
    end else begin
      have_modify <= any;
      rr <= any ? ~sel_l : rr;
      if (any) {entry_modify, destination_modify, value_modify} <= bus;
    end
endmodule

// File: tb/tb_cdb_bcast.sv
// tb_cdb_bcast: directed scenarios with a per-source scoreboard checked on every broadcast.
module tb_cdb_bcast;
  localparam int D = 4;
  localparam int TW = 4;
`ifdef CDB_BCAST_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  typedef logic [TW+36:0] ent_t;
  logic clk_in = 1'b0, rst_in, rdy_in, flush_in;
  logic alu_valid, alu_ready, lsb_valid, lsb_ready, have_modify;
  logic [TW-1:0] alu_tag, lsb_tag, entry_modify;
  logic [4:0] alu_rd, lsb_rd, destination_modify;
  logic [31:0] alu_value, lsb_value, value_modify;
  ent_t aq[$], lq[$], got, exp_e;
  int src_log[$];
  int n_chk = 0, n_fail = 0, n_bc = 0, pa = 0, ba = 0, mark;
  logic fell;

  cdb_bcast #(.FIFO_DEPTH(D), .TAG_W(TW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_tag(alu_tag), .alu_rd(alu_rd), .alu_value(alu_value),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_tag(lsb_tag), .lsb_rd(lsb_rd), .lsb_value(lsb_value),
    .have_modify(have_modify), .entry_modify(entry_modify),
    .destination_modify(destination_modify), .value_modify(value_modify)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic ent_t mk(input int t, input int rd, input logic [31:0] v);
    logic [TW-1:0] tt;
    logic [4:0] rr5;
    tt = t[TW-1:0];
    rr5 = rd[4:0];
    return {tt, rr5, v};
  endfunction

  // ALU results always use rd[4]=0 and LSB results rd[4]=1, so the bus tells the source
  always @(negedge clk_in)
    if (rst_in === 1'b1 && have_modify === 1'b1) begin
      got = {entry_modify, destination_modify, value_modify};
      n_bc++;
      src_log.push_back(int'(destination_modify[4]));
      if (destination_modify[4]) begin
        chk("bcast_lsb_expected", lq.size() != 0, 1);
        if (lq.size() != 0) begin
          exp_e = lq.pop_front();
          chk("bcast_lsb_data", got, exp_e);
        end
      end else begin
        chk("bcast_alu_expected", aq.size() != 0, 1);
        if (aq.size() != 0) begin
          exp_e = aq.pop_front();
          chk("bcast_alu_data", got, exp_e);
          ba++;
        end
      end
    end

  // called and returns at negedge+1; one rising edge per call
  task automatic cyc(input logic av, input ent_t ae, input logic lv, input ent_t le, input logic rdy, input logic fl);
    alu_valid = av;
    {alu_tag, alu_rd, alu_value} = ae;
    lsb_valid = lv;
    {lsb_tag, lsb_rd, lsb_value} = le;
    rdy_in = rdy;
    flush_in = fl;
    #1;
    if (rdy && fl) begin
      aq.delete();
      lq.delete();
      pa = 0;
      ba = 0;
    end else begin
      if (av && alu_ready && rdy) begin aq.push_back(ae); pa++; end
      if (lv && lsb_ready && rdy) lq.push_back(le);
    end
    @(negedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (aq.size() + lq.size()) != 0; i++) idle(1);
    chk("drain_empty", aq.size() + lq.size(), 0);
    idle(3);
  endtask

  task automatic do_reset(input string tag);
    rst_in = 1'b0;
    rdy_in = 1'b0;
    flush_in = 1'b0;
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    #1;
    aq.delete();
    lq.delete();
    pa = 0;
    ba = 0;
    chk({tag, "_have"}, have_modify, 0);
    chk({tag, "_out"}, {entry_modify, destination_modify, value_modify}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk({tag, "_ready_rdy0"}, {alu_ready, lsb_ready}, 2'b00);
    rdy_in = 1'b1;
    #1;
    chk({tag, "_ready_rdy1"}, {alu_ready, lsb_ready}, 2'b11);
    @(negedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b0;
    do_reset("init");

    // single result and its latency
    mark = n_bc;
    cyc(1, mk(3, 5, 32'h1234_5678), 0, '0, 1, 0);
    chk("single_edge1_have", have_modify, BYP);
    idle(1);
    chk("single_edge2_have", have_modify, !BYP);
    chk("single_tag", entry_modify, 3);
    chk("single_rd", destination_modify, 5);
    chk("single_value", value_modify, 32'h1234_5678);
    idle(1);
    chk("single_edge3_have", have_modify, 0);
    chk("single_count", n_bc - mark, 1);

    // reset mid-stream with results still queued
    do_reset("rst_a");
    for (int i = 0; i < 3; i++)
      cyc(1, mk(i, i, 32'hA200_0000 + i), 1, mk(i, 16 + i, 32'hB200_0000 + i), 1, 0);
    do_reset("rst_mid");
    mark = n_bc;
    idle(5);
    chk("rst_no_stale", n_bc - mark, 0);
    cyc(0, '0, 1, mk(9, 20, 32'hB2FF_0001), 1, 0);
    drain();
    chk("rst_first_after", n_bc - mark, 1);

    // contention starts from rr=0 after reset
    do_reset("cont");
    src_log.delete();
    mark = n_bc;
    for (int i = 0; i < 3; i++)
      cyc(1, mk(i, i, 32'hA000_0000 + i), 1, mk(8 + i, 16 + i, 32'hB000_0000 + i), 1, 0);
    drain();
    chk("cont_count", n_bc - mark, 6);
    for (int i = 0; i < 6 && i < src_log.size(); i++) chk("cont_order", src_log[i], i % 2);

    // both sources saturated: ALU fills, ready tracks occupancy
    do_reset("bp");
    fell = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, mk(i, i % 16, 32'hA100_0000 + i), 1, mk(i, 16 + i % 16, 32'hB100_0000 + i), 1, 0);
      chk("bp_ready_model", alu_ready, (pa - ba) < D);
      if (!alu_ready) fell = 1'b1;
    end
    chk("bp_ready_fell", fell, 1);
    drain();

    // flush with a concurrent ALU push
    do_reset("fl");
    for (int i = 0; i < 4; i++)
      cyc(1, mk(i, i, 32'hA300_0000 + i), 1, mk(i, 16 + i, 32'hB300_0000 + i), 1, 0);
    cyc(1, mk(15, 15, 32'hA3FF_FFFF), 0, '0, 1, 1);
    mark = n_bc;
    chk("fl_have", have_modify, 0);
    chk("fl_ready", {alu_ready, lsb_ready}, 2'b11);
    idle(6);
    chk("fl_silent", n_bc - mark, 0);

    // stall with two results queued
    do_reset("st");
    mark = n_bc;
    cyc(1, mk(4, 4, 32'hA400_0004), 1, mk(6, 22, 32'hB400_0006), 1, 0);
    cyc(0, '0, 0, '0, 0, 0);
    chk("st_have_0", have_modify, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, '0, 0, '0, 0, 1);
      chk("st_have", have_modify, 0);
      chk("st_ready", {alu_ready, lsb_ready}, 2'b00);
    end
    chk("st_count_during", n_bc - mark, int'(BYP));
    drain();
    chk("st_count_total", n_bc - mark, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
